alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the 16-bit ALU.
- Holds the 16x16 register file and resolves writeback bypass.
- Selects register or extended immediate for the second operand.
- Presents FirstOperand/SecondOperand/ALUOpOut to the ALU through a registered valid/ready interface with a 2-entry skid buffer, so ALU-side stalls never drop an instruction.

Parameters:
- DATA_W, 16, operand and register width
- ADDR_W, 4, register address width (2**ADDR_W registers)
- IMM_W, 8, immediate field width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- InValid  in  1  decoded instruction present
- InReady  out  1  stage can accept an instruction this cycle
- Rs1Addr  in  ADDR_W  first source register
- Rs2Addr  in  ADDR_W  second source register
- ImmData  in  IMM_W  immediate field
- UseImm  in  1  1: second operand from immediate; 0: from Rs2
- ALUOpIn  in  3  ALU operation code, passed through
- WrEn  in  1  writeback write enable
- WrAddr  in  ADDR_W  writeback register
- WrData  in  DATA_W  writeback data
- OutValid  out  1  operands valid toward ALU
- OutReady  in  1  ALU consumes operands this cycle
- FirstOperand  out  DATA_W  ALU first input
- SecondOperand  out  DATA_W  ALU second input
- ALUOpOut  out  3  ALU operation code

Behaviour:
- Reset (async, active-high):
  - All registers are cleared to 0.
  - OutValid=0; FirstOperand=SecondOperand=0; ALUOpOut=0; skid empty.
  - InReady=1 while Reset is high and after release.
- Register file:
  - Register 0 reads as 0; writes to it are ignored.
  - Write occurs on the rising edge when WrEn=1 and WrAddr!=0.
- Read with bypass:
  - Reads are combinational.
  - If WrEn=1, WrAddr!=0 and WrAddr equals the read address, the read returns WrData (same-cycle write-to-read bypass).
- Second operand:
  - UseImm=0: Rs2 value.
  - UseImm=1 and ALUOpIn is 4 or 5 (shifts): immediate zero-extended.
  - UseImm=1 and any other ALUOpIn: immediate sign-extended from bit IMM_W-1.
- Accept:
  - An instruction is accepted when InValid&&InReady.
  - Operands are captured at that edge. Latency is 1 cycle from accept to OutValid when the output is empty.
- Entries hold the values captured at accept; later register writes do not update them. RAW hazard control is upstream's responsibility.
- Handshake:
  - Output transfer occurs when OutValid&&OutReady.
  - Once OutValid=1, the output fields stay stable until transfer.
  - InReady = !skid_valid (registered, no combinational path from OutReady).
- State machine (main = output register, skid = overflow register):
  - EMPTY:
    - accept -> MAIN (load main).
  - MAIN:
    - accept and transfer -> MAIN (main reloaded).
    - accept without transfer -> FULL (load skid).
    - transfer without accept -> EMPTY.
    - neither -> MAIN.
  - FULL:
    - InReady=0.
    - transfer -> MAIN (skid moves to main).
    - otherwise -> FULL.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Reset mid-operation discards both entries and clears the register file.

Test Plan:
1. Write R3=0x1234, R5=0x0010; accept Rs1=3, Rs2=5, UseImm=0, ALUOpIn=1, OutReady=1 -> next cycle OutValid=1, FirstOperand=0x1234, SecondOperand=0x0010, ALUOpOut=1.
2. Bypass: accept Rs1=7 in the same cycle as WrEn=1, WrAddr=7, WrData=0xBEEF -> FirstOperand=0xBEEF. Accept Rs1=0 with a write to R0 of 0xFFFF -> FirstOperand=0x0000.
3. Immediate extension: ImmData=0xF0, UseImm=1, ALUOpIn=0 -> SecondOperand=0xFFF0. Same ImmData with ALUOpIn=4 -> SecondOperand=0x00F0.
4. Backpressure: OutReady=0, three back-to-back InValid=1 instructions A, B, C -> A in main, B in skid, InReady=0 so C is held. Raise OutReady -> ALU receives A, B, C in order with no loss and no duplication.
5. Full throughput: InValid=1 and OutReady=1 for 10 cycles -> one transfer per cycle; InReady stays 1 throughout.
6. Assert Reset while FULL -> OutValid=0 immediately, InReady=1, and all registers read 0 after release.

Source files
------------

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Brief    : Operand-fetch stage ahead of the ALU. Holds the register file
//             with writeback bypass, forms the second operand from a register
//             or an extended immediate, and presents operands through a
//             registered valid/ready output backed by a one-entry skid slot.
//  Revision : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [ADDR_W-1:0] Rs1Addr,
    input  logic [ADDR_W-1:0] Rs2Addr,
    input  logic [IMM_W-1:0]  ImmData,
    input  logic              UseImm,
    input  logic [2:0]        ALUOpIn,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] FirstOperand,
    output logic [DATA_W-1:0] SecondOperand,
    output logic [2:0]        ALUOpOut
);

    localparam int NREGS = 2 ** ADDR_W;

    // EMPTY: nothing held; MAIN: output register valid; FULL: skid also valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   rf_q [NREGS];
    logic [DATA_W-1:0]   rf_d [NREGS];
    logic [DATA_W-1:0]   main_a_q, main_a_d, main_b_q, main_b_d;
    logic [2:0]          main_op_q, main_op_d;
    logic [DATA_W-1:0]   skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic [2:0]          skid_op_q, skid_op_d;

    logic                wr_ok;
    logic [DATA_W-1:0]   rs1_val, rs2_val, imm_ext, new_b;
    logic                accept, transfer;

    assign wr_ok = WrEn && (WrAddr != '0);

    // Register reads with same-cycle writeback bypass; R0 is hard-wired to zero
    always_comb begin
        rs1_val = rf_q[Rs1Addr];
        rs2_val = rf_q[Rs2Addr];
        if (wr_ok && (WrAddr == Rs1Addr)) rs1_val = WrData;
        if (wr_ok && (WrAddr == Rs2Addr)) rs2_val = WrData;
        if (Rs1Addr == '0) rs1_val = '0;
        if (Rs2Addr == '0) rs2_val = '0;
    end

    // Shift amounts (ops 4 and 5) are unsigned; all other immediates are signed
    always_comb begin
        if ((ALUOpIn == 3'd4) || (ALUOpIn == 3'd5))
            imm_ext = {{(DATA_W-IMM_W){1'b0}}, ImmData};
        else
            imm_ext = {{(DATA_W-IMM_W){ImmData[IMM_W-1]}}, ImmData};
        new_b = UseImm ? imm_ext : rs2_val;
    end

    // Register file next-state: single write port, R0 never written
    always_comb begin
        rf_d = rf_q;
        if (wr_ok) rf_d[WrAddr] = WrData;
    end

    // InReady depends only on registered state, never on OutReady
    assign InReady  = (state_q != FULL);
    assign OutValid = (state_q != EMPTY);
    assign accept   = InValid && InReady;
    assign transfer = OutValid && OutReady;

    assign FirstOperand  = main_a_q;
    assign SecondOperand = main_b_q;
    assign ALUOpOut      = main_op_q;

    // Output-register / skid-slot sequencing; entries move strictly in order
    always_comb begin
        state_d   = state_q;
        main_a_d  = main_a_q;
        main_b_d  = main_b_q;
        main_op_d = main_op_q;
        skid_a_d  = skid_a_q;
        skid_b_d  = skid_b_q;
        skid_op_d = skid_op_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_a_d  = rs1_val;
                    main_b_d  = new_b;
                    main_op_d = ALUOpIn;
                    state_d   = MAIN;
                end
            end
            MAIN: begin
                if (accept && transfer) begin
                    main_a_d  = rs1_val;
                    main_b_d  = new_b;
                    main_op_d = ALUOpIn;
                end else if (accept) begin
                    skid_a_d  = rs1_val;
                    skid_b_d  = new_b;
                    skid_op_d = ALUOpIn;
                    state_d   = FULL;
                end else if (transfer) begin
                    state_d   = EMPTY;
                end
            end
            FULL: begin
                if (transfer) begin
                    main_a_d  = skid_a_q;
                    main_b_d  = skid_b_q;
                    main_op_d = skid_op_q;
                    state_d   = MAIN;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // All state, including the register file, clears on asynchronous reset
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= EMPTY;
            main_a_q  <= '0;
            main_b_q  <= '0;
            main_op_q <= '0;
            skid_a_q  <= '0;
            skid_b_q  <= '0;
            skid_op_q <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            main_a_q  <= main_a_d;
            main_b_q  <= main_b_d;
            main_op_q <= main_op_d;
            skid_a_q  <= skid_a_d;
            skid_b_q  <= skid_b_d;
            skid_op_q <= skid_op_d;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Brief    : Self-checking bench for alu_operand_stage: a queue-based model of
//             the stage is compared against the outputs every cycle, alongside
//             directed scenarios with literal expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        InValid, InReady;
    logic [3:0]  Rs1Addr, Rs2Addr;
    logic [7:0]  ImmData;
    logic        UseImm;
    logic [2:0]  ALUOpIn;
    logic        WrEn;
    logic [3:0]  WrAddr;
    logic [15:0] WrData;
    logic        OutValid, OutReady;
    logic [15:0] FirstOperand, SecondOperand;
    logic [2:0]  ALUOpOut;

    int checks = 0;
    int errors = 0;

    alu_operand_stage #(.DATA_W(16), .ADDR_W(4), .IMM_W(8)) dut (
        .CLK(CLK), .Reset(Reset),
        .InValid(InValid), .InReady(InReady),
        .Rs1Addr(Rs1Addr), .Rs2Addr(Rs2Addr), .ImmData(ImmData),
        .UseImm(UseImm), .ALUOpIn(ALUOpIn),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .OutValid(OutValid), .OutReady(OutReady),
        .FirstOperand(FirstOperand), .SecondOperand(SecondOperand),
        .ALUOpOut(ALUOpOut)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
    } ent_t;

    logic [15:0] regs [16];
    ent_t        q[$];
    logic [15:0] recv[$];

    function automatic logic [15:0] model_read(input logic [3:0] addr);
        if (addr == 4'd0) return 16'h0000;
        if (WrEn && WrAddr != 4'd0 && WrAddr == addr) return WrData;
        return regs[addr];
    endfunction

    function automatic logic [15:0] model_b();
        int v;
        if (!UseImm) return model_read(Rs2Addr);
        v = ImmData;
        if (ALUOpIn != 3'd4 && ALUOpIn != 3'd5 && v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            q.delete();
            for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        end else begin
            bit   acc, xfer;
            ent_t e;
            acc  = InValid && (q.size() < 2);
            xfer = (q.size() > 0) && OutReady;
            e.a  = model_read(Rs1Addr);
            e.b  = model_b();
            e.op = ALUOpIn;
            if (xfer) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (WrEn && WrAddr != 4'd0) regs[WrAddr] = WrData;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (!Reset) begin
            bit          ev;
            logic [15:0] ea, eb;
            logic [2:0]  eo;
            ev = (q.size() > 0);
            ea = ev ? q[0].a : FirstOperand;
            eb = ev ? q[0].b : SecondOperand;
            eo = ev ? q[0].op : ALUOpOut;
            checks++;
            if (OutValid !== ev || InReady !== (q.size() < 2) ||
                FirstOperand !== ea || SecondOperand !== eb || ALUOpOut !== eo) begin
                errors++;
                $display("FAIL model t=%0t got v=%b r=%b a=%h b=%h op=%0d exp v=%b r=%b a=%h b=%h op=%0d",
                         $time, OutValid, InReady, FirstOperand, SecondOperand, ALUOpOut,
                         ev, (q.size() < 2), ea, eb, eo);
            end
            if (OutValid && OutReady) recv.push_back(SecondOperand);
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1; InValid = 0; Rs1Addr = 0; Rs2Addr = 0; ImmData = 0;
        UseImm = 0; ALUOpIn = 0; WrEn = 0; WrAddr = 0; WrData = 0; OutReady = 1;
        #1;
        check("reset_outvalid", 16'(OutValid), 16'h0);
        check("reset_inready", 16'(InReady), 16'h1);
        tick(); tick();
        Reset = 1'b0;
        tick();
        check("post_reset_first", FirstOperand, 16'h0000);

        // 1: register read
        WrEn = 1; WrAddr = 3; WrData = 16'h1234; tick();
        WrAddr = 5; WrData = 16'h0010; tick();
        WrEn = 0; InValid = 1; Rs1Addr = 3; Rs2Addr = 5; UseImm = 0; ALUOpIn = 1;
        tick();
        InValid = 0;
        @(negedge CLK);
        check("t1_valid", 16'(OutValid), 16'h1);
        check("t1_first", FirstOperand, 16'h1234);
        check("t1_second", SecondOperand, 16'h0010);
        check("t1_op", 16'(ALUOpOut), 16'h1);

        // 2: bypass and R0
        tick();
        InValid = 1; Rs1Addr = 7; WrEn = 1; WrAddr = 7; WrData = 16'hBEEF; tick();
        Rs1Addr = 0; WrAddr = 0; WrData = 16'hFFFF;
        @(negedge CLK);
        check("t2_bypass", FirstOperand, 16'hBEEF);
        tick();
        InValid = 0; WrEn = 0;
        @(negedge CLK);
        check("t2_r0", FirstOperand, 16'h0000);

        // 3: immediate extension
        tick();
        InValid = 1; UseImm = 1; ImmData = 8'hF0; ALUOpIn = 0; tick();
        ALUOpIn = 4;
        @(negedge CLK);
        check("t3_sext", SecondOperand, 16'hFFF0);
        tick();
        InValid = 0;
        @(negedge CLK);
        check("t3_zext", SecondOperand, 16'h00F0);
        tick(); tick();

        // 4: backpressure A, B, C
        recv.delete();
        OutReady = 0; ALUOpIn = 1; UseImm = 1;
        InValid = 1; ImmData = 8'd1; tick();
        ImmData = 8'd2; tick();
        ImmData = 8'd3;
        @(negedge CLK);
        check("t4_inready_full", 16'(InReady), 16'h0);
        check("t4_main_is_A", SecondOperand, 16'h0001);
        tick();
        OutReady = 1; tick(); tick();
        InValid = 0; tick(); tick();
        check("t4_count", 16'(recv.size()), 16'd3);
        if (recv.size() == 3) begin
            check("t4_A", recv[0], 16'd1);
            check("t4_B", recv[1], 16'd2);
            check("t4_C", recv[2], 16'd3);
        end

        // 5: full throughput
        recv.delete();
        for (int i = 0; i < 10; i++) begin
            InValid = 1; ImmData = 8'(i + 16); UseImm = 1; ALUOpIn = 3'(i);
            tick();
            @(negedge CLK);
            check("t5_inready", 16'(InReady), 16'h1);
        end
        InValid = 0; tick(); tick(); tick();
        check("t5_transfers", 16'(recv.size()), 16'd10);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            InValid  = 1'($urandom);
            OutReady = ($urandom_range(0, 3) != 0);
            Rs1Addr  = 4'($urandom); Rs2Addr = 4'($urandom);
            ImmData  = 8'($urandom); UseImm = 1'($urandom);
            ALUOpIn  = 3'($urandom);
            WrEn     = 1'($urandom); WrData = 16'($urandom);
            WrAddr   = ($urandom_range(0, 3) == 0) ? Rs1Addr : 4'($urandom);
            tick();
        end
        InValid = 0; WrEn = 0; OutReady = 1; tick(); tick(); tick();

        // 6: reset while FULL
        WrEn = 1; WrAddr = 9; WrData = 16'h5A5A; tick(); WrEn = 0;
        OutReady = 0; InValid = 1; UseImm = 0; Rs1Addr = 9; tick(); tick();
        InValid = 0;
        @(negedge CLK);
        check("t6_full", 16'(InReady), 16'h0);
        #1 Reset = 1'b1;
        #1;
        check("t6_rst_outvalid", 16'(OutValid), 16'h0);
        check("t6_rst_inready", 16'(InReady), 16'h1);
        tick();
        Reset = 1'b0; OutReady = 1;
        for (int i = 1; i < 16; i++) begin
            InValid = 1; Rs1Addr = 4'(i); Rs2Addr = 4'(i); UseImm = 0;
            tick();
            @(negedge CLK);
            check("t6_reg_cleared", FirstOperand | SecondOperand, 16'h0000);
        end
        InValid = 0; tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
